lock_client_sequencer: RTL and testbench

// - Synchronous front-end for the 8-way asynchronous mutual-exclusion arbiter tree.
// - Converts level-style, clocked client lock requests into 4-phase req/ack handshakes
//   on the tree leaves, and synchronizes the tree's asynchronous acks.
// - Presents a clean, registered per-client grant.
// - Polices the tree: flags release timeouts and any mutual-exclusion violation.

---
 rtl/lock_pkg.sv | 25 ++
 rtl/lock_chan_fsm.sv | 105 ++++++++++
 rtl/lock_client_sequencer.sv | 54 +++++
 tb/tb_lock_client_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and defaults for the lock client sequencer: channel state
// encoding, default sizes and a small popcount helper for the mutex check.
package lock_pkg;

  localparam int N_REQ_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_W_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    HELD    = 3'd2,
    RELEASE = 3'd3,
    STUCK   = 3'd4,
    COOL    = 3'd5
  } chan_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/lock_chan_fsm.sv
// One lock channel: arb_ack synchronizer, 4-phase req/ack handshake FSM,
// release-timeout counter and sticky per-channel fault flag.
module lock_chan_fsm
  import lock_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT_W   = TIMEOUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cli_req,
  input  logic                 arb_ack,
  input  logic [TIMEOUT_W-1:0] timeout_cfg,
  input  logic                 err_clr,
  output logic                 cli_grant,
  output logic                 arb_req,
  output logic                 err,
  output logic                 ack_s,
  output logic                 active
);

  logic [SYNC_STAGES-1:0] sync_q;
  chan_state_e            state;
  logic [TIMEOUT_W-1:0]   tcnt;
  logic                   tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], arb_ack};
  end

  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign tmo_hit = (timeout_cfg != '0) && (tcnt == timeout_cfg - TIMEOUT_W'(1));

  // Outputs are registered alongside the state, so each transition sets them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      err       <= 1'b0;
      arb_req   <= 1'b0;
      cli_grant <= 1'b0;
      active    <= 1'b0;
    end else begin
      tcnt <= '0;
      // NOTE: with non-blocking assignments the last write in the block wins,
      // so a fault setting err below overrides this same-cycle clear.
      if (err_clr) err <= 1'b0;

      case (state)
        IDLE: begin
          // A stale ack from a previous owner must drain before re-requesting.
          if (cli_req && !ack_s) begin
            state   <= REQ;
            arb_req <= 1'b1;
            active  <= 1'b1;
          end
        end
        REQ: begin
          if (ack_s) begin
            if (cli_req) begin
              state     <= HELD;
              cli_grant <= 1'b1;
            end else begin
              state   <= RELEASE;
              arb_req <= 1'b0;
            end
          end
        end
        HELD: begin
          if (!ack_s || !cli_req) begin
            state     <= RELEASE;
            arb_req   <= 1'b0;
            cli_grant <= 1'b0;
            if (!ack_s) err <= 1'b1;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            state <= COOL;
          end else if (tmo_hit) begin
            state <= STUCK;
            err   <= 1'b1;
          end else begin
            tcnt <= (tcnt == '1) ? tcnt : tcnt + TIMEOUT_W'(1);
          end
        end
        STUCK: begin
          if (!ack_s) state <= COOL;
        end
        COOL: begin
          state  <= IDLE;
          active <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          arb_req   <= 1'b0;
          cli_grant <= 1'b0;
          active    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lock_client_sequencer.sv
// Synchronous front-end for the asynchronous mutex arbiter tree: one handshake
// channel per client plus tree-wide mutual-exclusion policing.
module lock_client_sequencer
  import lock_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT_W   = TIMEOUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     cli_req,
  output logic [N_REQ-1:0]     cli_grant,
  output logic [N_REQ-1:0]     arb_req,
  input  logic [N_REQ-1:0]     arb_ack,
  input  logic [TIMEOUT_W-1:0] timeout_cfg,
  input  logic                 err_clr,
  output logic [N_REQ-1:0]     err,
  output logic                 mutex_err,
  output logic                 busy
);

  logic [N_REQ-1:0] ack_s;
  logic [N_REQ-1:0] active;

  for (genvar i = 0; i < N_REQ; i++) begin : g_chan
    lock_chan_fsm #(
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT_W   (TIMEOUT_W)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .cli_req     (cli_req[i]),
      .arb_ack     (arb_ack[i]),
      .timeout_cfg (timeout_cfg),
      .err_clr     (err_clr),
      .cli_grant   (cli_grant[i]),
      .arb_req     (arb_req[i]),
      .err         (err[i]),
      .ack_s       (ack_s[i]),
      .active      (active[i])
    );
  end

  // More than one leaf acknowledged at once means the tree broke exclusion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          mutex_err <= 1'b0;
    else if (popcount8(8'(ack_s)) > 4'd1) mutex_err <= 1'b1;
    else if (err_clr)                    mutex_err <= 1'b0;
  end

  assign busy = |active;

endmodule

// File: tb/tb_lock_client_sequencer.sv
// Bench for lock_client_sequencer: a behavioural arbiter-tree model drives
// arb_ack, and a spec-level channel model predicts every output each cycle.
module tb_lock_client_sequencer;

  localparam int N  = 8;
  localparam int SS = 2;
  localparam int TW = 8;

  localparam int P_IDLE = 0, P_REQ = 1, P_HELD = 2, P_REL = 3, P_STUCK = 4, P_COOL = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  cli_req = '0;
  logic [N-1:0]  cli_grant;
  logic [N-1:0]  arb_req;
  logic [N-1:0]  arb_ack = '0;
  logic [TW-1:0] timeout_cfg = '0;
  logic          err_clr = 1'b0;
  logic [N-1:0]  err;
  logic          mutex_err;
  logic          busy;

  always #5 clk = ~clk;

  lock_client_sequencer #(.N_REQ(N), .SYNC_STAGES(SS), .TIMEOUT_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cli_req     (cli_req),
    .cli_grant   (cli_grant),
    .arb_req     (arb_req),
    .arb_ack     (arb_ack),
    .timeout_cfg (timeout_cfg),
    .err_clr     (err_clr),
    .err         (err),
    .mutex_err   (mutex_err),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-channel phase, cycles spent releasing, sticky flags
  // and the ack delay line seen by the decision logic.
  int           ph [N];
  int           rel[N];
  logic [N-1:0] m_err;
  logic         m_mutex;
  logic [N-1:0] m_pipe[SS];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ph[i]  = P_IDLE;
      rel[i] = 0;
    end
    for (int s = 0; s < SS; s++) m_pipe[s] = '0;
    m_err   = '0;
    m_mutex = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] as;
    as = m_pipe[SS-1];
    if ($countones(as) > 1) m_mutex = 1'b1;
    else if (err_clr)       m_mutex = 1'b0;
    for (int i = 0; i < N; i++) begin
      bit fault;
      fault = 1'b0;
      case (ph[i])
        P_IDLE:  if (cli_req[i] && !as[i]) ph[i] = P_REQ;
        P_REQ:   if (as[i]) ph[i] = cli_req[i] ? P_HELD : P_REL;
        P_HELD: begin
          if (!as[i]) begin fault = 1'b1; ph[i] = P_REL; end
          else if (!cli_req[i]) ph[i] = P_REL;
        end
        P_REL: begin
          rel[i]++;
          if (!as[i]) ph[i] = P_COOL;
          else if (timeout_cfg != 0 && rel[i] == int'(timeout_cfg)) begin
            fault = 1'b1;
            ph[i] = P_STUCK;
          end
        end
        P_STUCK: if (!as[i]) ph[i] = P_COOL;
        default: ph[i] = P_IDLE;
      endcase
      if (ph[i] != P_REL) rel[i] = 0;
      if (fault)        m_err[i] = 1'b1;
      else if (err_clr) m_err[i] = 1'b0;
    end
    for (int s = SS - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
    m_pipe[0] = arb_ack;
  endtask

  // Arbiter tree model: grants the earliest pending leaf after a latency,
  // holds ack until that leaf drops its request (unless hold_ack pins it).
  int           owner;
  int           pend[$];
  logic [N-1:0] in_pend;
  logic [N-1:0] tree_ack;
  logic [N-1:0] hold_ack;
  int           gwait;
  int           gdelay;
  int           fix_lat;
  bit           rand_lat;
  bit           force_en;
  logic [N-1:0] force_val;

  task automatic tree_reset();
    owner = -1;
    pend.delete();
    in_pend  = '0;
    tree_ack = '0;
    hold_ack = '0;
    gwait    = 0;
    gdelay   = 0;
    fix_lat  = 0;
    rand_lat = 1'b0;
    force_en = 1'b0;
    force_val = '0;
  endtask

  task automatic tree_update();
    if (owner >= 0 && !arb_req[owner] && !hold_ack[owner]) begin
      tree_ack[owner] = 1'b0;
      owner = -1;
      gwait = 0;
    end
    for (int i = 0; i < N; i++)
      if (arb_req[i] && !in_pend[i] && owner != i) begin
        pend.push_back(i);
        in_pend[i] = 1'b1;
      end
    while (pend.size() > 0 && !arb_req[pend[0]]) begin
      in_pend[pend[0]] = 1'b0;
      void'(pend.pop_front());
    end
    if (owner < 0 && pend.size() > 0) begin
      if (gwait >= gdelay) begin
        owner = pend.pop_front();
        in_pend[owner]  = 1'b0;
        tree_ack[owner] = 1'b1;
        gwait  = 0;
        gdelay = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
      end else begin
        gwait++;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg, er;
    logic eb;
    eg = '0; er = '0; eb = 1'b0;
    for (int i = 0; i < N; i++) begin
      eg[i] = (ph[i] == P_HELD);
      er[i] = (ph[i] == P_REQ) || (ph[i] == P_HELD);
      if (ph[i] != P_IDLE) eb = 1'b1;
    end
    check($sformatf("cli_grant@%0d", cyc), cli_grant, eg);
    check($sformatf("arb_req@%0d", cyc), arb_req, er);
    check($sformatf("err@%0d", cyc), err, m_err);
    check($sformatf("mutex_err@%0d", cyc), mutex_err, m_mutex);
    check($sformatf("busy@%0d", cyc), busy, eb);
  endtask

  // Called at a falling edge: apply inputs, advance the model, compare next.
  task automatic cycle();
    tree_update();
    arb_ack = force_en ? force_val : tree_ack;
    if (rst_n) model_step();
    else       model_reset();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic drain();
    cli_req  = '0;
    hold_ack = '0;
    for (int k = 0; k < 60 && (busy || owner >= 0); k++) cycle();
    for (int k = 0; k < 3; k++) cycle();
    check("drain_busy", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int cfg_tab[6];
    int ca, r1;
    bit seen;
    cfg_tab = '{0, 1, 2, 3, 4, 8};

    model_reset();
    tree_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_grant", cli_grant, 8'h00);
    check("rst_arb_req", arb_req, 8'h00);
    check("rst_err", err, 8'h00);
    check("rst_mutex", mutex_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Single client: ack 3 cycles after the request, grant SS+1 edges later.
    cyc = 0; fix_lat = 2; gdelay = 2; gwait = 0;
    cli_req[3] = 1'b1;
    while (cyc < 16) begin
      if (cyc == 10) cli_req[3] = 1'b0;
      cycle();
      if (cyc == 1)  check("t1_arb_req_rise", arb_req[3], 1'b1);
      if (cyc == 5)  check("t1_grant_early", cli_grant[3], 1'b0);
      if (cyc == 6)  check("t1_grant_rise", cli_grant[3], 1'b1);
      if (cyc == 11) check("t1_arb_req_fall", arb_req[3], 1'b0);
      if (cyc == 14) check("t1_cool_busy", busy, 1'b1);
      if (cyc == 15) check("t1_idle", busy, 1'b0);
    end
    drain();

    // Contention: two same-cycle requests, tree picks leaf 0 first.
    fix_lat = 1; gdelay = 1; gwait = 0;
    cli_req = 8'h03;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      check("t2_never_both", cli_grant == 8'h03, 1'b0);
      if (cli_grant != '0 && !seen) begin
        check("t2_first", cli_grant, 8'h01);
        seen = 1'b1;
      end
    end
    check("t2_granted", seen, 1'b1);
    cli_req[0] = 1'b0;
    cycle();
    check("t2_gap", cli_grant, 8'h00);
    for (int k = 0; k < 15 && cli_grant == '0; k++) cycle();
    check("t2_second", cli_grant, 8'h02);
    drain();

    // Cancel: one-cycle request, ack arrives ~10 cycles later.
    fix_lat = 9; gdelay = 9; gwait = 0;
    cli_req[5] = 1'b1;
    cycle();
    cli_req[5] = 1'b0;
    ca = -1;
    for (int k = 0; k < 25; k++) begin
      cycle();
      check("t3_no_grant", cli_grant[5], 1'b0);
      if (ca < 0 && arb_ack[5]) ca = cyc - 1;
      if (ca >= 0 && cyc == ca + 2) check("t3_req_held", arb_req[5], 1'b1);
      if (ca >= 0 && cyc == ca + 3) check("t3_req_fall", arb_req[5], 1'b0);
    end
    check("t3_saw_ack", ca >= 0, 1'b1);
    drain();

    // Release timeout: tree keeps ack[2] high after the request drops.
    fix_lat = 0; gdelay = 0; gwait = 0;
    timeout_cfg = 8'd4;
    cli_req[2] = 1'b1;
    for (int k = 0; k < 20 && !cli_grant[2]; k++) cycle();
    check("t4_granted", cli_grant[2], 1'b1);
    hold_ack[2] = 1'b1;
    cli_req[2]  = 1'b0;
    cycle();
    r1 = cyc;
    while (cyc < r1 + 3) cycle();
    check("t4_err_early", err[2], 1'b0);
    cycle();
    check("t4_err_set", err[2], 1'b1);
    for (int k = 0; k < 3; k++) cycle();
    check("t4_stuck_busy", busy, 1'b1);
    hold_ack[2] = 1'b0;
    for (int k = 0; k < 20 && busy; k++) cycle();
    check("t4_idle", busy, 1'b0);
    check("t4_sticky", err[2], 1'b1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("t4_clr", err, 8'h00);
    timeout_cfg = '0;
    drain();

    // Mutex violation: two acks forced high together.
    force_en = 1'b1; force_val = 8'h03;
    cycle();
    cycle();
    check("t5_mutex_early", mutex_err, 1'b0);
    cycle();
    check("t5_mutex_set", mutex_err, 1'b1);
    force_en = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    check("t5_mutex_sticky", mutex_err, 1'b1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("t5_mutex_clr", mutex_err, 1'b0);
    drain();

    // Reset while client 7 holds the lock; tree keeps ack up for a while.
    cli_req[7] = 1'b1;
    for (int k = 0; k < 20 && !cli_grant[7]; k++) cycle();
    check("t6_granted", cli_grant[7], 1'b1);
    hold_ack[7] = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_grant", cli_grant, 8'h00);
    check("t6_rst_arb_req", arb_req, 8'h00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_err", {err, mutex_err}, 9'h000);
    @(negedge clk);
    cli_req[7] = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    cli_req[7] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t6_stale_wait", arb_req[7], 1'b0);
    end
    hold_ack[7] = 1'b0;
    for (int k = 0; k < 10 && !arb_req[7]; k++) cycle();
    check("t6_rereq", arb_req[7], 1'b1);
    drain();

    // Randomized traffic against the model.
    rand_lat = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (k % 250 == 0) timeout_cfg = TW'(cfg_tab[$urandom_range(0, 5)]);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) cli_req[i] = ~cli_req[i];
      err_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end
    err_clr = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
